alu_protocol_checker: RTL and testbench
=======================================

# alu_protocol_checker

Synthesizable, parametrised protocol and result checker for the TinyALU family, bound next to the DUT in the testbench and reusable in emulation. It tracks every transaction from `start` through `done` with a small FSM and a latency counter, then recomputes the expected result. It reports sticky error flags, single-cycle error pulses and saturating transaction and error counters. Unlike a pure property file, it keeps scoreboard state and is configurable in data width and per-class latency.

## Interface
Parameters:
- DATA_W, 8: operand width; result is 2*DATA_W.
- SINGLE_LAT, 1: cycles from start capture to the required `done` for ADD/AND/XOR.
- MULT_LAT, 3: the same for MUL; must satisfy MULT_LAT >= 1.
- CNT_W, 16: width of the counters.

Ports:
- clk  in  1  clock; all logic samples on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- A, B  in  DATA_W each  DUT operands.
- op  in  3  0=NOP, 1=ADD, 2=AND, 3=XOR, 4=MUL; 5..7 treated as NOP.
- start, done  in  1 each  DUT handshake.
- result  in  2*DATA_W  DUT result.
- clr  in  1  synchronous clear of flags and counters.
- busy  out  1  a transaction is being tracked.
- err_flags  out  4  sticky flags: [0] EARLY, [1] LATE, [2] RESULT, [3] PROTO.
- err_pulse  out  1  high for exactly one cycle per detected error.
- txn_count  out  CNT_W  transactions checked at their `done` edge; saturating.
- err_count  out  CNT_W  errors detected; saturating.

## Operation
- FSM states are IDLE and BUSY.
- **IDLE start:** at an edge with start=1 and op in 1..4, the checker captures A, B and op, sets cnt=1 and LAT, and moves to BUSY.
- **IDLE done:** done=1 in IDLE flags EARLY, including any `done` for a NOP.
- **BUSY, cnt<LAT:**
  - done=1 flags EARLY; the checker goes to IDLE.
  - start=0, or A/B/op differing from the captured values, flags PROTO; the checker goes to IDLE and does not check the result.
  - Otherwise cnt increments.
  - EARLY has priority over PROTO in the same edge.
- **BUSY, cnt==LAT:** start and operands are not checked.
  - done=1: txn_count increments. If result differs from the expected value, RESULT is flagged. The checker goes to IDLE.
  - done=0: LATE is flagged and the checker goes to IDLE. A later stray `done` then flags EARLY, and this double report is intentional.
- **Expected result** is computed from the captured operands:
  - ADD: zero-extended sum, so the carry lands in bit DATA_W.
  - AND / XOR: zero-extended.
  - MUL: full 2*DATA_W product.
- **Counters:** err_count increments by one per error edge, since at most one error can occur per edge. Both counters saturate at all-ones.
- **clr:** clears err_flags and both counters. It does not affect the FSM. An error on the same edge wins: the new flag is set and the count becomes 1.
- **New transactions:** a transaction can start only from IDLE. If start is still high on the edge after `done`, a new transaction begins.

## Timing
- **Reset:** every output and all state reset to 0 (IDLE, cnt=0). Reset asserted mid-transaction abandons it silently.
- **Registered outputs:** busy, err_flags, err_pulse and the counters are all registered.
- **Error visibility:** an error detected at edge k shows on err_pulse and err_flags after edge k. err_pulse drops after edge k+1 unless another error occurs.
- **`done` timing:** with start captured at edge k, `done` must be sampled high at edge k+LAT, and low at edges k+1 .. k+LAT-1.
- **busy:** rises after edge k and falls after the terminating edge.

## Structure
- Package `alu_chk_pkg` holds:
  - the op enum,
  - the FSM state enum,
  - error-bit index constants ERR_EARLY=0, ERR_LATE=1, ERR_RESULT=2, ERR_PROTO=3.
- Sub-module `alu_chk_expect` is purely combinational. It maps the captured op, A and B to the expected result, is parametrised by DATA_W, and is reused by the UVM scoreboard DPI-free model.

## Test plan
All scenarios use DATA_W=8, SINGLE_LAT=1, MULT_LAT=3.
1. ADD with A=8'hFF, B=8'h01, start held, done=1 at k+1 with result 16'h0100 -> err_flags 0, txn_count 1, busy high for exactly one cycle.
2. MUL with A=B=8'hFF:
   - done at k+3 with result 16'hFE01 -> no error.
   - Repeat with result 16'hFE00 -> err_flags[2] set, err_pulse one cycle, err_count 1.
3. MUL:
   - done at k+2 -> err_flags[0].
   - Separate run with done never asserted -> err_flags[1] after k+3, and a later done at k+5 -> err_count 2.
4. MUL with op changed 4->1 at k+1 -> err_flags[3], busy low after k+1, txn_count unchanged.
5. op=0 with start=1, done pulsed -> err_flags[0]; busy never rises.
6. Three cases:
   - reset_n low at k+1 of a MUL -> all outputs 0 immediately, no error afterwards.
   - clr with err_count=5 -> 0.
   - err_count forced to 16'hFFFF by errors -> stays 16'hFFFF.

Source files
------------

// File: rtl/alu_chk_pkg.sv
// Shared types and constants for the TinyALU protocol and result checker.
package alu_chk_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_MUL = 3'd4
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } chk_state_e;

  localparam int ERR_EARLY  = 0;
  localparam int ERR_LATE   = 1;
  localparam int ERR_RESULT = 2;
  localparam int ERR_PROTO  = 3;

  // Opcodes 5..7 behave as NOP, so only 1..4 open a transaction.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op >= OP_ADD) && (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/alu_chk_expect.sv
// Combinational reference model: maps a captured op and operands to the
// result the TinyALU must return.
module alu_chk_expect
  import alu_chk_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]          op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] expected
);

  logic [2*DATA_W-1:0] a_ext_s;
  logic [2*DATA_W-1:0] b_ext_s;

  assign a_ext_s = {{DATA_W{1'b0}}, a};
  assign b_ext_s = {{DATA_W{1'b0}}, b};

  // Select the reference result; ADD carry lands in bit DATA_W
  always_comb begin
    expected = {(2*DATA_W){1'b0}};
    case (op)
      OP_ADD:  expected = a_ext_s + b_ext_s;
      OP_AND:  expected = a_ext_s & b_ext_s;
      OP_XOR:  expected = a_ext_s ^ b_ext_s;
      OP_MUL:  expected = a_ext_s * b_ext_s;
      default: expected = {(2*DATA_W){1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_protocol_checker.sv
// Tracks each TinyALU transaction from start to done, checks handshake timing
// and result, and keeps sticky flags, error pulses and saturating counters.
module alu_protocol_checker
  import alu_chk_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int SINGLE_LAT = 1,
  parameter int MULT_LAT   = 3,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  input  logic [2:0]          op,
  input  logic                start,
  input  logic                done,
  input  logic [2*DATA_W-1:0] result,
  input  logic                clr,
  output logic                busy,
  output logic [3:0]          err_flags,
  output logic                err_pulse,
  output logic [CNT_W-1:0]    txn_count,
  output logic [CNT_W-1:0]    err_count
);

  localparam int MAX_LAT = (MULT_LAT > SINGLE_LAT) ? MULT_LAT : SINGLE_LAT;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  chk_state_e          state_r, state_nxt_s;
  logic [LAT_W-1:0]    cnt_r, cnt_nxt_s;
  logic [LAT_W-1:0]    lat_r, lat_new_s;
  logic [DATA_W-1:0]   a_r, b_r;
  logic [2:0]          op_r;
  logic [2*DATA_W-1:0] expected_s;
  logic                capture_s;
  logic                operand_diff_s;
  logic                txn_inc_s;
  logic                err_any_s;
  logic [3:0]          err_bits_s;
  logic                busy_r;
  logic                err_pulse_r;
  logic [3:0]          err_flags_r;
  logic [CNT_W-1:0]    txn_count_r;
  logic [CNT_W-1:0]    err_count_r;

  alu_chk_expect #(.DATA_W(DATA_W)) u_expect (
    .op       (op_r),
    .a        (a_r),
    .b        (b_r),
    .expected (expected_s)
  );

  assign lat_new_s      = (op == OP_MUL) ? LAT_W'(MULT_LAT) : LAT_W'(SINGLE_LAT);
  assign operand_diff_s = (A != a_r) || (B != b_r) || (op != op_r);
  assign err_any_s      = |err_bits_s;

  // Next-state logic and per-edge error classification
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    capture_s   = 1'b0;
    txn_inc_s   = 1'b0;
    err_bits_s  = 4'b0000;
    case (state_r)
      ST_IDLE: begin
        if (done) begin
          err_bits_s[ERR_EARLY] = 1'b1;
        end else begin
          err_bits_s = 4'b0000;
        end
        if (start && is_alu_op(op)) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_BUSY;
          cnt_nxt_s   = LAT_W'(1);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r < lat_r) begin
          // An early done outranks a protocol violation on the same edge
          if (done) begin
            err_bits_s[ERR_EARLY] = 1'b1;
            state_nxt_s           = ST_IDLE;
          end else if (!start || operand_diff_s) begin
            err_bits_s[ERR_PROTO] = 1'b1;
            state_nxt_s           = ST_IDLE;
          end else begin
            cnt_nxt_s = cnt_r + LAT_W'(1);
          end
        end else begin
          state_nxt_s = ST_IDLE;
          if (done) begin
            txn_inc_s              = 1'b1;
            err_bits_s[ERR_RESULT] = (result != expected_s);
          end else begin
            err_bits_s[ERR_LATE] = 1'b1;
          end
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state, latency counter and captured transaction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {LAT_W{1'b0}};
      lat_r   <= {LAT_W{1'b0}};
      a_r     <= {DATA_W{1'b0}};
      b_r     <= {DATA_W{1'b0}};
      op_r    <= 3'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s == ST_BUSY);
      if (capture_s) begin
        lat_r <= lat_new_s;
        a_r   <= A;
        b_r   <= B;
        op_r  <= op;
      end
    end
  end

  // Sticky flags, error pulse and saturating counters; a same-edge error beats clr
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_pulse_r <= 1'b0;
      err_flags_r <= 4'b0000;
      txn_count_r <= {CNT_W{1'b0}};
      err_count_r <= {CNT_W{1'b0}};
    end else begin
      err_pulse_r <= err_any_s;
      if (clr) begin
        err_flags_r <= err_bits_s;
        err_count_r <= {{(CNT_W-1){1'b0}}, err_any_s};
        txn_count_r <= {{(CNT_W-1){1'b0}}, txn_inc_s};
      end else begin
        err_flags_r <= err_flags_r | err_bits_s;
        if (err_any_s && (err_count_r != CNT_MAX)) begin
          err_count_r <= err_count_r + CNT_ONE;
        end
        if (txn_inc_s && (txn_count_r != CNT_MAX)) begin
          txn_count_r <= txn_count_r + CNT_ONE;
        end
      end
    end
  end

  assign busy      = busy_r;
  assign err_flags = err_flags_r;
  assign err_pulse = err_pulse_r;
  assign txn_count = txn_count_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_alu_protocol_checker.sv
// Self-checking bench for alu_protocol_checker: directed vector table, hand
// sequences for multi-cycle corners, and random traffic against a reference model.
module tb_alu_protocol_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  a, b;
  logic [2:0]  op;
  logic        start, done, clr;
  logic [15:0] result;
  logic        busy, err_pulse;
  logic [3:0]  err_flags;
  logic [15:0] txn_count, err_count;

  int errors = 0;
  int checks = 0;

  // Reference model state: edge index of capture instead of a latency counter
  int          edge_n = 0;
  bit          m_act = 1'b0;
  int          m_cap = 0;
  logic [7:0]  m_a, m_b;
  logic [2:0]  m_op;
  bit          e_busy = 1'b0, e_pulse = 1'b0;
  logic [3:0]  e_flags = 4'b0000;
  int          e_txn = 0, e_err = 0;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a, b;
    int          done_at;   // cycles after capture; 0 = never
    logic [15:0] res;
    logic [3:0]  flags;
    int          txn, err, busy_cyc;
  } vec_t;

  vec_t vecs[10];

  alu_protocol_checker #(.DATA_W(8), .SINGLE_LAT(1), .MULT_LAT(3), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .A(a), .B(b), .op(op), .start(start), .done(done),
    .result(result), .clr(clr), .busy(busy), .err_flags(err_flags), .err_pulse(err_pulse),
    .txn_count(txn_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_result(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int ix, iy;
    ix = int'(x);
    iy = int'(y);
    case (o)
      3'd1: return 16'(ix + iy);
      3'd2: return 16'(ix & iy);
      3'd3: return 16'(ix ^ iy);
      3'd4: return 16'(ix * iy);
      default: return 16'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 1'b0; e_busy = 1'b0; e_pulse = 1'b0; e_flags = 4'b0000; e_txn = 0; e_err = 0;
  endtask

  task automatic model_edge();
    logic [3:0] nb;
    bit txn;
    int lat;
    nb = 4'b0000;
    txn = 1'b0;
    edge_n++;
    if (m_act) begin
      lat = (m_op == 3'd4) ? 3 : 1;
      if (edge_n < m_cap + lat) begin
        if (done) nb[0] = 1'b1;
        else if (!start || a !== m_a || b !== m_b || op !== m_op) nb[3] = 1'b1;
        if (nb != 4'b0000) m_act = 1'b0;
      end else begin
        txn = done;
        if (done && result !== ref_result(m_op, m_a, m_b)) nb[2] = 1'b1;
        if (!done) nb[1] = 1'b1;
        m_act = 1'b0;
      end
    end else begin
      if (done) nb[0] = 1'b1;
      if (start && op >= 3'd1 && op <= 3'd4) begin
        m_act = 1'b1; m_cap = edge_n; m_a = a; m_b = b; m_op = op;
      end
    end
    if (clr) begin
      e_flags = nb;
      e_err   = (nb != 4'b0000) ? 1 : 0;
      e_txn   = txn ? 1 : 0;
    end else begin
      e_flags = e_flags | nb;
      if (nb != 4'b0000 && e_err < 65535) e_err++;
      if (txn && e_txn < 65535) e_txn++;
    end
    e_pulse = (nb != 4'b0000);
    e_busy  = m_act;
  endtask

  task automatic compare_all();
    chk("busy",      32'(busy),      32'(e_busy));
    chk("err_flags", 32'(err_flags), 32'(e_flags));
    chk("err_pulse", 32'(err_pulse), 32'(e_pulse));
    chk("txn_count", 32'(txn_count), 32'(e_txn));
    chk("err_count", 32'(err_count), 32'(e_err));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic d, input logic [15:0] r, input logic c);
    start = s; op = o; a = x; b = y; done = d; result = r; clr = c;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int lat, n, busy_cnt;
    v = vecs[idx];
    lat = (v.op == 3'd4) ? 3 : 1;
    n = (v.done_at != 0 && v.done_at < lat) ? v.done_at : lat;
    busy_cnt = 0;
    drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b1); cycle();
    drive(1'b1, v.op, v.a, v.b, 1'b0, 16'd0, 1'b0); cycle();
    if (busy) busy_cnt++;
    for (int i = 1; i <= n; i++) begin
      drive(1'b1, v.op, v.a, v.b, (i == v.done_at), v.res, 1'b0); cycle();
      if (busy) busy_cnt++;
    end
    drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b0); cycle();
    if (busy) busy_cnt++;
    chk($sformatf("vec%0d flags", idx), 32'(err_flags), 32'(v.flags));
    chk($sformatf("vec%0d txn", idx),   32'(txn_count), 32'(v.txn));
    chk($sformatf("vec%0d err", idx),   32'(err_count), 32'(v.err));
    chk($sformatf("vec%0d busy_cycles", idx), 32'(busy_cnt), 32'(v.busy_cyc));
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [2:0] rop;
    logic rs, rd, rc;
    logic [15:0] rr;

    //         op    a      b      at res       flags    txn err busy
    vecs[0] = '{3'd1, 8'hFF, 8'h01, 1, 16'h0100, 4'b0000, 1, 0, 1};
    vecs[1] = '{3'd4, 8'hFF, 8'hFF, 3, 16'hFE01, 4'b0000, 1, 0, 3};
    vecs[2] = '{3'd4, 8'hFF, 8'hFF, 3, 16'hFE00, 4'b0100, 1, 1, 3};
    vecs[3] = '{3'd4, 8'h12, 8'h34, 2, 16'h03A8, 4'b0001, 0, 1, 2};
    vecs[4] = '{3'd2, 8'hF0, 8'h3C, 1, 16'h0030, 4'b0000, 1, 0, 1};
    vecs[5] = '{3'd3, 8'hF0, 8'h3C, 1, 16'h00CC, 4'b0000, 1, 0, 1};
    vecs[6] = '{3'd3, 8'hF0, 8'h3C, 1, 16'h00CD, 4'b0100, 1, 1, 1};
    vecs[7] = '{3'd1, 8'h80, 8'h80, 1, 16'h0100, 4'b0000, 1, 0, 1};
    vecs[8] = '{3'd4, 8'h12, 8'h34, 3, 16'h03A8, 4'b0000, 1, 0, 3};
    vecs[9] = '{3'd4, 8'h12, 8'h34, 0, 16'h0000, 4'b0010, 0, 1, 3};

    reset_n = 1'b0;
    drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b0);
    #12;
    model_reset();
    compare_all();
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i);

    // Missing done gives LATE, then a stray done at k+5 gives EARLY
    drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b1); cycle();
    drive(1'b1, 3'd4, 8'h05, 8'h07, 1'b0, 16'd0, 1'b0); cycle();
    for (int i = 1; i <= 3; i++) cycle();
    chk("late flag", 32'(err_flags), 32'(4'b0010));
    drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b0); cycle();
    drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 16'd0, 1'b0); cycle();
    drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b0); cycle();
    chk("late+early flags", 32'(err_flags), 32'(4'b0011));
    chk("late+early count", 32'(err_count), 32'd2);

    // Op changes mid-transaction
    drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b1); cycle();
    drive(1'b1, 3'd4, 8'h21, 8'h43, 1'b0, 16'd0, 1'b0); cycle();
    drive(1'b1, 3'd1, 8'h21, 8'h43, 1'b0, 16'd0, 1'b0); cycle();
    chk("proto busy", 32'(busy), 32'd0);
    chk("proto flags", 32'(err_flags), 32'(4'b1000));
    chk("proto txn", 32'(txn_count), 32'd0);
    drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b0); cycle();

    // NOP with start never becomes busy, its done is EARLY
    drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b1); cycle();
    drive(1'b1, 3'd0, 8'h11, 8'h22, 1'b0, 16'd0, 1'b0); cycle();
    chk("nop busy", 32'(busy), 32'd0);
    drive(1'b1, 3'd0, 8'h11, 8'h22, 1'b1, 16'd0, 1'b0); cycle();
    chk("nop busy2", 32'(busy), 32'd0);
    chk("nop flags", 32'(err_flags), 32'(4'b0001));

    // Reset in the middle of a MUL
    drive(1'b1, 3'd4, 8'h33, 8'h44, 1'b0, 16'd0, 1'b0); cycle();
    cycle();
    #2 reset_n = 1'b0;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst flags", 32'(err_flags), 32'd0);
    chk("rst pulse", 32'(err_pulse), 32'd0);
    chk("rst txn", 32'(txn_count), 32'd0);
    chk("rst err", 32'(err_count), 32'd0);
    model_reset();
    #1 reset_n = 1'b1;
    drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 4; i++) cycle();
    chk("post-rst err", 32'(err_count), 32'd0);

    // Five errors then clr
    drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 16'd0, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b0); cycle();
    chk("err five", 32'(err_count), 32'd5);
    drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b1); cycle();
    chk("clr err", 32'(err_count), 32'd0);
    chk("clr flags", 32'(err_flags), 32'd0);

    // Drive err_count past all-ones
    drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 16'd0, 1'b0);
    for (int i = 0; i < 65540; i++) cycle();
    chk("err saturate", 32'(err_count), 32'h0000FFFF);

    // Random traffic against the model
    drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b1); cycle();
    ra = 8'($urandom); rb = 8'($urandom); rop = 3'd1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) ra = 8'($urandom);
      if ($urandom_range(0, 9) == 0) rb = 8'($urandom);
      if ($urandom_range(0, 6) == 0) rop = 3'($urandom_range(0, 7));
      rs = ($urandom_range(0, 9) < 8);
      rd = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 4) != 0) ? ref_result(rop, ra, rb) : 16'($urandom);
      rc = ($urandom_range(0, 49) == 0);
      if (rc) rd = 1'b0;
      drive(rs, rop, ra, rb, rd, rr, rc);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
